// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_hazard_stage
// Brief   : ID/EX pipeline register with load-use stall, flush bubble and
//           saturating stall counter.
// Revision: 1.0
// ============================================================================
module id_ex_hazard_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [7:0]        id_ctrl,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [7:0]        ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int         C_MEM_READ_BIT = 6;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic              ex_valid_q,    ex_valid_d;
    logic [REG_AW-1:0] ex_rs1_q,      ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q,      ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
    logic [DATA_W-1:0] ex_rdata1_q,   ex_rdata1_d;
    logic [DATA_W-1:0] ex_rdata2_q,   ex_rdata2_d;
    logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
    logic [7:0]        ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_haz;

    // Hazard looks only at registered EX state, so stall is free of en.
    always_comb begin
        w_rs1_match = id_uses_rs1 && (id_rs1 == ex_rd_q);
        w_rs2_match = id_uses_rs2 && (id_rs2 == ex_rd_q);
        w_haz       = ex_valid_q && ex_ctrl_q[C_MEM_READ_BIT] && (ex_rd_q != '0) &&
                      id_valid && (w_rs1_match || w_rs2_match);
    end

    assign stall = w_haz && !flush;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_rdata1_d   = ex_rdata1_q;
        ex_rdata2_d   = ex_rdata2_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_count_d = stall_count_q;
        if (en) begin
            // Fields always follow ID so a bubble carries deterministic contents.
            ex_rs1_d    = id_rs1;
            ex_rs2_d    = id_rs2;
            ex_rd_d     = id_rd;
            ex_rdata1_d = id_rdata1;
            ex_rdata2_d = id_rdata2;
            ex_imm_d    = id_imm;
            if (flush) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
            end else if (w_haz) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                if (stall_count_q != C_CNT_MAX) begin
                    stall_count_d = stall_count_q + 1'b1;
                end
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? id_ctrl : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rdata1_q   <= '0;
            ex_rdata2_q   <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_rdata1_q   <= ex_rdata1_d;
            ex_rdata2_q   <= ex_rdata2_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rdata1   = ex_rdata1_q;
    assign ex_rdata2   = ex_rdata2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
